// File: rtl/alu_pkg.sv
// alu_pkg: types and constants shared by the decoder and the ALU.
//   alu_sel_e  - ALU operation select codes
//   a_src_e    - operand A source (RS1, RS2, IMM)
//   b_src_e    - operand B source (RS1, RS2, IMM, PC)
//   OPC_*      - RV32I major opcodes handled by the decoder
//   f3_sel     - funct3 -> operation map shared by OP and OP-IMM
package alu_pkg;

  localparam int SEL_SIZE_DEF   = 4;
  localparam int SHIFT_SIZE_DEF = 5;

  typedef enum logic [3:0] {
    SEL_ADD   = 4'd0,
    SEL_SUB   = 4'd1,
    SEL_SLT   = 4'd2,
    SEL_SLTU  = 4'd3,
    SEL_AND   = 4'd4,
    SEL_OR    = 4'd5,
    SEL_XOR   = 4'd6,
    SEL_SLL   = 4'd7,
    SEL_SRL   = 4'd8,
    SEL_SRA   = 4'd9,
    SEL_LUI   = 4'd10,
    SEL_AUIPC = 4'd11,
    SEL_LOAD  = 4'd12,
    SEL_STORE = 4'd13
  } alu_sel_e;

  typedef enum logic [1:0] {
    A_RS1 = 2'd0,
    A_RS2 = 2'd1,
    A_IMM = 2'd2
  } a_src_e;

  typedef enum logic [1:0] {
    B_RS1 = 2'd0,
    B_RS2 = 2'd1,
    B_IMM = 2'd2,
    B_PC  = 2'd3
  } b_src_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  // Base (funct7 = 0) meaning of funct3 for register and immediate ALU ops.
  function automatic alu_sel_e f3_sel(input logic [2:0] f3);
    alu_sel_e s;
    s = SEL_ADD;
    case (f3)
      3'b000:  s = SEL_ADD;
      3'b001:  s = SEL_SLL;
      3'b010:  s = SEL_SLT;
      3'b011:  s = SEL_SLTU;
      3'b100:  s = SEL_XOR;
      3'b101:  s = SEL_SRL;
      3'b110:  s = SEL_OR;
      default: s = SEL_AND;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/alu_decode_comb.sv
// alu_decode_comb: purely combinational RV32I decode of one instruction word.
// Ports:
//   instr          in  32          instruction word
//   sel            out alu_sel_e   ALU operation
//   a_src / b_src  out 2 / 2       operand sources
//   shift_amt      out SHIFT_SIZE+1 immediate shift amount (OP-IMM shifts)
//   shamt_from_rs2 out 1           register shifts take amount from rs2
//   rd, rs1, rs2   out 5 each      register fields (zeroed when illegal)
//   imm            out XLEN        decoded immediate
//   alu_enable     out 1           legal op
//   illegal        out 1           unsupported opcode/funct combination
module alu_decode_comb
  import alu_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int SHIFT_SIZE = SHIFT_SIZE_DEF
) (
  input  logic [31:0]         instr,
  output alu_sel_e            sel,
  output a_src_e              a_src,
  output b_src_e              b_src,
  output logic [SHIFT_SIZE:0] shift_amt,
  output logic                shamt_from_rs2,
  output logic [4:0]          rd,
  output logic [4:0]          rs1,
  output logic [4:0]          rs2,
  output logic [XLEN-1:0]     imm,
  output logic                alu_enable,
  output logic                illegal
);

  localparam int SW = SHIFT_SIZE + 1;

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [XLEN-1:0] imm_i;
  logic [XLEN-1:0] imm_s;
  logic [XLEN-1:0] imm_u;
  logic            legal;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];
  assign imm_i  = {{(XLEN-12){instr[31]}}, instr[31:20]};
  assign imm_s  = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
  // U-field is delivered unshifted; the ALU positions it.
  assign imm_u  = XLEN'(instr[31:12]);

  always_comb begin
    legal          = 1'b0;
    sel            = SEL_ADD;
    a_src          = A_RS1;
    b_src          = B_RS1;
    shift_amt      = '0;
    shamt_from_rs2 = 1'b0;
    imm            = '0;
    rd             = instr[11:7];
    rs1            = instr[19:15];
    rs2            = instr[24:20];

    case (opcode)
      OPC_OP: begin
        a_src = A_RS1;
        b_src = B_RS2;
        if (funct7 == F7_BASE) begin
          legal          = 1'b1;
          sel            = f3_sel(funct3);
          shamt_from_rs2 = (funct3 == 3'b001) || (funct3 == 3'b101);
        end else if (funct7 == F7_ALT && funct3 == 3'b000) begin
          // Execute computes b - a, so the operands swap for SUB.
          legal = 1'b1;
          sel   = SEL_SUB;
          a_src = A_RS2;
          b_src = B_RS1;
        end else if (funct7 == F7_ALT && funct3 == 3'b101) begin
          legal          = 1'b1;
          sel            = SEL_SRA;
          shamt_from_rs2 = 1'b1;
        end
      end
      OPC_OP_IMM: begin
        a_src = A_RS1;
        b_src = B_IMM;
        imm   = imm_i;
        sel   = f3_sel(funct3);
        case (funct3)
          3'b001: begin
            legal     = (funct7 == F7_BASE);
            shift_amt = SW'(instr[24:20]);
          end
          3'b101: begin
            legal     = (funct7 == F7_BASE) || (funct7 == F7_ALT);
            sel       = (funct7 == F7_ALT) ? SEL_SRA : SEL_SRL;
            shift_amt = SW'(instr[24:20]);
          end
          default: legal = 1'b1;
        endcase
      end
      OPC_LUI: begin
        legal = 1'b1;
        sel   = SEL_LUI;
        a_src = A_IMM;
        imm   = imm_u;
      end
      OPC_AUIPC: begin
        legal = 1'b1;
        sel   = SEL_AUIPC;
        a_src = A_IMM;
        b_src = B_PC;
        imm   = imm_u;
      end
      OPC_LOAD: begin
        legal = (funct3 != 3'b011) && (funct3 != 3'b110) && (funct3 != 3'b111);
        sel   = SEL_LOAD;
        b_src = B_IMM;
        imm   = imm_i;
      end
      OPC_STORE: begin
        legal = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);
        sel   = SEL_STORE;
        b_src = B_IMM;
        imm   = imm_s;
        rd    = 5'd0;
      end
      default: legal = 1'b0;
    endcase

    // Illegal ops still flow downstream, but carry nothing usable.
    if (!legal) begin
      sel            = SEL_ADD;
      a_src          = A_RS1;
      b_src          = B_RS1;
      shift_amt      = '0;
      shamt_from_rs2 = 1'b0;
      imm            = '0;
      rd             = 5'd0;
      rs1            = 5'd0;
      rs2            = 5'd0;
    end

    alu_enable = legal;
    illegal    = !legal;
  end

endmodule

// File: rtl/alu_decoder.sv
// alu_decoder: RV32I ALU decoder with a one-entry valid/ready output register.
// Ports:
//   clk, reset_n                 clock, async active-low reset
//   in_valid/in_ready            instruction handshake (in_instr, in_pc)
//   flush                        drop the held op; blocks acceptance this cycle
//   out_valid/out_ready          decoded-op handshake to execute
//   alu_enable, alu_sel, alu_shift_amt, shamt_from_rs2, a_src, b_src,
//   rd, rs1, rs2, imm, out_pc, illegal   registered decode results
//   illegal_count                saturating count of accepted illegal ops
module alu_decoder
  import alu_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int SEL_SIZE   = SEL_SIZE_DEF,
  parameter int SHIFT_SIZE = SHIFT_SIZE_DEF
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [31:0]         in_instr,
  input  logic [XLEN-1:0]     in_pc,
  input  logic                flush,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                alu_enable,
  output logic [SEL_SIZE-1:0] alu_sel,
  output logic [SHIFT_SIZE:0] alu_shift_amt,
  output logic                shamt_from_rs2,
  output logic [1:0]          a_src,
  output logic [1:0]          b_src,
  output logic [4:0]          rd,
  output logic [4:0]          rs1,
  output logic [4:0]          rs2,
  output logic [XLEN-1:0]     imm,
  output logic [XLEN-1:0]     out_pc,
  output logic                illegal,
  output logic [15:0]         illegal_count
);

  alu_sel_e            d_sel;
  a_src_e              d_a;
  b_src_e              d_b;
  logic [SHIFT_SIZE:0] d_shamt;
  logic                d_from_rs2;
  logic [4:0]          d_rd;
  logic [4:0]          d_rs1;
  logic [4:0]          d_rs2;
  logic [XLEN-1:0]     d_imm;
  logic                d_enable;
  logic                d_illegal;
  logic                accept;

  assign in_ready = !flush && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

  alu_decode_comb #(
    .XLEN       (XLEN),
    .SHIFT_SIZE (SHIFT_SIZE)
  ) u_decode (
    .instr          (in_instr),
    .sel            (d_sel),
    .a_src          (d_a),
    .b_src          (d_b),
    .shift_amt      (d_shamt),
    .shamt_from_rs2 (d_from_rs2),
    .rd             (d_rd),
    .rs1            (d_rs1),
    .rs2            (d_rs2),
    .imm            (d_imm),
    .alu_enable     (d_enable),
    .illegal        (d_illegal)
  );

  // Flush wins over both a hold and (since in_ready is low) a new accept.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)          out_valid <= 1'b0;
    else if (flush)        out_valid <= 1'b0;
    else if (accept)       out_valid <= 1'b1;
    else if (out_ready)    out_valid <= 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      alu_enable     <= 1'b0;
      alu_sel        <= '0;
      alu_shift_amt  <= '0;
      shamt_from_rs2 <= 1'b0;
      a_src          <= '0;
      b_src          <= '0;
      rd             <= '0;
      rs1            <= '0;
      rs2            <= '0;
      imm            <= '0;
      out_pc         <= '0;
      illegal        <= 1'b0;
    end else if (accept) begin
      alu_enable     <= d_enable;
      alu_sel        <= SEL_SIZE'(d_sel);
      alu_shift_amt  <= d_shamt;
      shamt_from_rs2 <= d_from_rs2;
      a_src          <= d_a;
      b_src          <= d_b;
      rd             <= d_rd;
      rs1            <= d_rs1;
      rs2            <= d_rs2;
      imm            <= d_imm;
      out_pc         <= in_pc;
      illegal        <= d_illegal;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      illegal_count <= '0;
    else if (accept && d_illegal && illegal_count != 16'hFFFF)
      illegal_count <= illegal_count + 16'd1;
  end

endmodule

// File: tb/tb_alu_decoder.sv
module tb_alu_decoder;

  logic        clk;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic        alu_enable;
  logic [3:0]  alu_sel;
  logic [5:0]  alu_shift_amt;
  logic        shamt_from_rs2;
  logic [1:0]  a_src;
  logic [1:0]  b_src;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [31:0] imm;
  logic [31:0] out_pc;
  logic        illegal;
  logic [15:0] illegal_count;

  alu_decoder dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_instr       (in_instr),
    .in_pc          (in_pc),
    .flush          (flush),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .alu_enable     (alu_enable),
    .alu_sel        (alu_sel),
    .alu_shift_amt  (alu_shift_amt),
    .shamt_from_rs2 (shamt_from_rs2),
    .a_src          (a_src),
    .b_src          (b_src),
    .rd             (rd),
    .rs1            (rs1),
    .rs2            (rs2),
    .imm            (imm),
    .out_pc         (out_pc),
    .illegal        (illegal),
    .illegal_count  (illegal_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        en;
    logic [3:0]  sel;
    logic [5:0]  shamt;
    logic        from_rs2;
    logic [1:0]  a;
    logic [1:0]  b;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic [31:0] pc;
    logic        illegal;
  } bundle_t;

  typedef struct {
    logic [31:0] instr;
    logic [3:0]  sel;
    logic [1:0]  a;
    logic [1:0]  b;
    logic [5:0]  shamt;
    logic        from_rs2;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic        illegal;
  } vec_t;

  // funct3 -> select code: ADD SLL SLT SLTU XOR SRL OR AND
  localparam logic [3:0] OP_SEL [8] = '{4'd0, 4'd7, 4'd2, 4'd3, 4'd6, 4'd8, 4'd5, 4'd4};

  int          n_pass = 0;
  int          n_total = 0;
  logic        m_valid;
  bundle_t     m_rec;
  logic [15:0] m_cnt;
  logic        last_acc;
  logic        track;
  logic [31:0] obs[$];
  vec_t        tbl[15];

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_total++;
    if (got !== exp)
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    else
      n_pass++;
  endtask

  function automatic bundle_t dut_bundle();
    bundle_t b;
    b.en = alu_enable;  b.sel = alu_sel;  b.shamt = alu_shift_amt;
    b.from_rs2 = shamt_from_rs2;  b.a = a_src;  b.b = b_src;
    b.rd = rd;  b.rs1 = rs1;  b.rs2 = rs2;  b.imm = imm;
    b.pc = out_pc;  b.illegal = illegal;
    return b;
  endfunction

  // Reference decode: straight from the instruction-set rules.
  function automatic bundle_t ref_decode(input logic [31:0] i, input logic [31:0] pc);
    bundle_t     e;
    logic        ok;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] simm;
    e    = '0;
    ok   = 1'b0;
    f3   = i[14:12];
    f7   = i[31:25];
    simm = {{20{i[31]}}, i[31:20]};
    e.rd = i[11:7];  e.rs1 = i[19:15];  e.rs2 = i[24:20];
    case (i[6:0])
      7'h33: begin
        e.b = 2'd1;
        if (f7 == 7'h00) begin
          ok = 1'b1;  e.sel = OP_SEL[f3];  e.from_rs2 = (f3 == 3'd1 || f3 == 3'd5);
        end else if (f7 == 7'h20 && f3 == 3'd0) begin
          ok = 1'b1;  e.sel = 4'd1;  e.a = 2'd1;  e.b = 2'd0;
        end else if (f7 == 7'h20 && f3 == 3'd5) begin
          ok = 1'b1;  e.sel = 4'd9;  e.from_rs2 = 1'b1;
        end
      end
      7'h13: begin
        e.b = 2'd2;  e.imm = simm;  e.sel = OP_SEL[f3];
        if (f3 == 3'd1)      ok = (f7 == 7'h00);
        else if (f3 == 3'd5) ok = (f7 == 7'h00 || f7 == 7'h20);
        else                 ok = 1'b1;
        if (f3 == 3'd5 && f7 == 7'h20) e.sel = 4'd9;
        if (f3 == 3'd1 || f3 == 3'd5)  e.shamt = {1'b0, i[24:20]};
      end
      7'h37: begin ok = 1'b1;  e.sel = 4'd10;  e.a = 2'd2;  e.imm = {12'h0, i[31:12]}; end
      7'h17: begin ok = 1'b1;  e.sel = 4'd11;  e.a = 2'd2;  e.b = 2'd3;  e.imm = {12'h0, i[31:12]}; end
      7'h03: begin
        ok = (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
        e.sel = 4'd12;  e.b = 2'd2;  e.imm = simm;
      end
      7'h23: begin
        ok = (f3 <= 3'd2);
        e.sel = 4'd13;  e.b = 2'd2;  e.imm = {{20{i[31]}}, i[31:25], i[11:7]};  e.rd = 5'd0;
      end
      default: ok = 1'b0;
    endcase
    if (!ok) begin
      e = '0;
      e.illegal = 1'b1;
    end
    e.en = ok;
    e.pc = pc;
    return e;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    logic [6:0]  opcs[6];
    int          k;
    opcs = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h03, 7'h23};
    r = $urandom;
    k = $urandom_range(0, 6);
    if (k < 6) r[6:0] = opcs[k];
    case ($urandom_range(0, 2))
      0: r[31:25] = 7'h00;
      1: r[31:25] = 7'h20;
      default: ;
    endcase
    return r;
  endfunction

  // One clock: check state at the falling edge, then advance the model.
  task automatic cycle();
    logic    m_ready;
    logic    acc;
    bundle_t e;
    e = '0;
    @(negedge clk);
    chk("out_valid", 128'(out_valid), 128'(m_valid));
    chk("outputs", 128'(dut_bundle()), 128'(m_rec));
    chk("illegal_count", 128'(illegal_count), 128'(m_cnt));
    m_ready = !flush && (!m_valid || out_ready);
    chk("in_ready", 128'(in_ready), 128'(m_ready));
    if (track && out_valid && out_ready) obs.push_back(out_pc);
    acc = in_valid && m_ready;
    last_acc = acc;
    if (acc) e = ref_decode(in_instr, in_pc);
    @(posedge clk);
    if (flush)          m_valid = 1'b0;
    else if (acc)       m_valid = 1'b1;
    else if (out_ready) m_valid = 1'b0;
    if (acc) begin
      m_rec = e;
      if (e.illegal && m_cnt != 16'hFFFF) m_cnt++;
    end
    #1;
  endtask

  task automatic model_reset();
    m_valid = 1'b0;
    m_rec   = '0;
    m_cnt   = '0;
  endtask

  task automatic check_reset_zero(input string tag);
    chk({tag, "_valid"}, 128'(out_valid), 128'(0));
    chk({tag, "_outputs"}, 128'(dut_bundle()), 128'(0));
    chk({tag, "_count"}, 128'(illegal_count), 128'(0));
  endtask

  initial begin
    bundle_t exp;
    int      idx;
    int      cyc;
    logic    pat[12];

    tbl[0]  = '{32'h40208033, 4'd1,  2'd1, 2'd0, 6'd0, 1'b0, 5'd0, 5'd1, 5'd2,  32'h00000000, 1'b0};
    tbl[1]  = '{32'h40315093, 4'd9,  2'd0, 2'd2, 6'd3, 1'b0, 5'd1, 5'd2, 5'd3,  32'h00000403, 1'b0};
    tbl[2]  = '{32'h003150B3, 4'd8,  2'd0, 2'd1, 6'd0, 1'b1, 5'd1, 5'd2, 5'd3,  32'h00000000, 1'b0};
    tbl[3]  = '{32'hFFC12083, 4'd12, 2'd0, 2'd2, 6'd0, 1'b0, 5'd1, 5'd2, 5'd28, 32'hFFFFFFFC, 1'b0};
    tbl[4]  = '{32'h123450B7, 4'd10, 2'd2, 2'd0, 6'd0, 1'b0, 5'd1, 5'd8, 5'd3,  32'h00012345, 1'b0};
    tbl[5]  = '{32'hFFFFFFFF, 4'd0,  2'd0, 2'd0, 6'd0, 1'b0, 5'd0, 5'd0, 5'd0,  32'h00000000, 1'b1};
    tbl[6]  = '{32'h00001097, 4'd11, 2'd2, 2'd3, 6'd0, 1'b0, 5'd1, 5'd0, 5'd0,  32'h00000001, 1'b0};
    tbl[7]  = '{32'h0020A423, 4'd13, 2'd0, 2'd2, 6'd0, 1'b0, 5'd0, 5'd1, 5'd2,  32'h00000008, 1'b0};
    tbl[8]  = '{32'hFE20AE23, 4'd13, 2'd0, 2'd2, 6'd0, 1'b0, 5'd0, 5'd1, 5'd2,  32'hFFFFFFFC, 1'b0};
    tbl[9]  = '{32'hFFF10093, 4'd0,  2'd0, 2'd2, 6'd0, 1'b0, 5'd1, 5'd2, 5'd31, 32'hFFFFFFFF, 1'b0};
    tbl[10] = '{32'h02208033, 4'd0,  2'd0, 2'd0, 6'd0, 1'b0, 5'd0, 5'd0, 5'd0,  32'h00000000, 1'b1};
    tbl[11] = '{32'h40111093, 4'd0,  2'd0, 2'd0, 6'd0, 1'b0, 5'd0, 5'd0, 5'd0,  32'h00000000, 1'b1};
    tbl[12] = '{32'h00013083, 4'd0,  2'd0, 2'd0, 6'd0, 1'b0, 5'd0, 5'd0, 5'd0,  32'h00000000, 1'b1};
    tbl[13] = '{32'h0020F1B3, 4'd4,  2'd0, 2'd1, 6'd0, 1'b0, 5'd3, 5'd1, 5'd2,  32'h00000000, 1'b0};
    tbl[14] = '{32'h00512093, 4'd2,  2'd0, 2'd2, 6'd0, 1'b0, 5'd1, 5'd2, 5'd5,  32'h00000005, 1'b0};

    track     = 1'b0;
    last_acc  = 1'b0;
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_instr  = '0;
    in_pc     = '0;
    flush     = 1'b0;
    out_ready = 1'b1;
    model_reset();
    #1;
    check_reset_zero("por");
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;

    // Directed vectors, back to back under out_ready=1.
    for (int i = 0; i < 15; i++) begin
      in_valid = 1'b1;
      in_instr = tbl[i].instr;
      in_pc    = 32'h1000 + 32'(i * 4);
      cycle();
      in_valid = 1'b0;
      exp = '{en: !tbl[i].illegal, sel: tbl[i].sel, shamt: tbl[i].shamt,
              from_rs2: tbl[i].from_rs2, a: tbl[i].a, b: tbl[i].b,
              rd: tbl[i].rd, rs1: tbl[i].rs1, rs2: tbl[i].rs2,
              imm: tbl[i].imm, pc: in_pc, illegal: tbl[i].illegal};
      chk($sformatf("vec%0d", i), 128'(dut_bundle()), 128'(exp));
      chk($sformatf("vec%0d_valid", i), 128'(out_valid), 128'(1));
      if (i == 5) chk("first_illegal_count", 128'(illegal_count), 128'(1));
    end
    cycle();

    // Backpressure: three stalled cycles, then irregular release.
    pat = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    obs.delete();
    track = 1'b1;
    idx = 0;
    cyc = 0;
    while ((idx < 5 || m_valid) && cyc < 40) begin
      in_valid  = (idx < 5);
      in_instr  = (idx < 5) ? tbl[idx].instr : 32'h0;
      in_pc     = 32'h2000 + 32'(idx * 4);
      out_ready = (cyc < 12) ? pat[cyc] : 1'b1;
      cycle();
      if (last_acc) idx++;
      cyc++;
    end
    track    = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk("bp_all_sent", 128'(idx), 128'(5));
    chk("bp_transfers", 128'(obs.size()), 128'(5));
    for (int k = 0; k < 5; k++)
      if (k < obs.size()) chk($sformatf("bp_order%0d", k), 128'(obs[k]), 128'(32'h2000 + 32'(k * 4)));

    // Flush while holding.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = tbl[13].instr;
    in_pc     = 32'h3000;
    cycle();
    flush     = 1'b1;
    in_instr  = tbl[0].instr;
    in_pc     = 32'h3004;
    cycle();
    chk("flush_clears", 128'(out_valid), 128'(0));
    flush    = 1'b0;
    in_valid = 1'b0;
    cycle();
    out_ready = 1'b1;
    cycle();

    // Randomized traffic.
    repeat (400) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 15) == 0);
      in_instr  = rand_instr();
      in_pc     = $urandom & 32'hFFFF_FFFC;
      cycle();
    end
    flush = 1'b0;

    // Reset in the middle of a held op.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = tbl[1].instr;
    in_pc     = 32'h4000;
    cycle();
    in_valid = 1'b0;
    cycle();
    #2 reset_n = 1'b0;
    #1;
    check_reset_zero("mid_reset");
    model_reset();
    @(posedge clk);
    #1 reset_n = 1'b1;
    cycle();
    out_ready = 1'b1;
    cycle();

    // Saturation of the illegal counter.
    in_valid = 1'b1;
    in_instr = 32'hFFFFFFFF;
    in_pc    = 32'h5000;
    repeat (65537) cycle();
    chk("count_saturated", 128'(illegal_count), 128'(16'hFFFF));
    flush = 1'b1;
    cycle();
    flush    = 1'b0;
    in_valid = 1'b0;
    cycle();
    chk("count_after_flush", 128'(illegal_count), 128'(16'hFFFF));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
